instr_dispatch_queue: RTL and testbench



---
 rtl/instr_dispatch_queue.sv | 151 +++++++++++++++
 tb/tb_instr_dispatch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch_queue.sv
// -----------------------------------------------------------------------------
// instr_dispatch_queue
//   Decode/dispatch front end for the wavefront controller. Each incoming
//   instruction is classified from its top opcode bits into SALU, BRANCH,
//   VALU or MEM. It is then buffered in that class's own circular FIFO, and
//   each FIFO is drained independently by its downstream unit decoder.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_ready depends on the class of in_data
//   in_data         instruction word (INSTR_SIZE bits)
//   in_wf_id        issuing wavefront ID
//   flush           synchronous clear of every queue
//   out_valid[c]    head of queue c valid (0 SALU, 1 BRANCH, 2 VALU, 3 MEM)
//   out_ready[c]    consumer of class c takes the head
//   out_data        slice c = {wf_id, instr} of the head of queue c
//   q_full[c]       queue c holds QUEUE_DEPTH entries
//   stall_count     saturating count of cycles with in_valid & ~in_ready
// -----------------------------------------------------------------------------
module instr_dispatch_queue #(
   parameter int unsigned INSTR_SIZE  = 32,
   parameter int unsigned WF_ID_W     = 4,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [INSTR_SIZE-1:0]               in_data,
   input  logic [WF_ID_W-1:0]                  in_wf_id,
   input  logic                                flush,
   output logic [3:0]                          out_valid,
   input  logic [3:0]                          out_ready,
   output logic [4*(WF_ID_W+INSTR_SIZE)-1:0]   out_data,
   output logic [3:0]                          q_full,
   output logic [STALL_CNT_W-1:0]              stall_count
);

   localparam int unsigned NUM_CLS = 4;
   localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = WF_ID_W + INSTR_SIZE;

   typedef enum logic [1:0] {
      CLS_SALU   = 2'd0,
      CLS_BRANCH = 2'd1,
      CLS_VALU   = 2'd2,
      CLS_MEM    = 2'd3
   } cls_e;

   cls_e                   cls;
   logic                   in_ready_int;
   logic                   accept;
   logic [NUM_CLS-1:0]     push_vec;
   logic [NUM_CLS-1:0]     pop_vec;
   logic [NUM_CLS-1:0]     valid_vec;
   logic [NUM_CLS-1:0]     full_vec;
   logic [ENTRY_W-1:0]     entry_d;

   logic [PTR_W-1:0]       wr_ptr_q [NUM_CLS];
   logic [PTR_W-1:0]       wr_ptr_d [NUM_CLS];
   logic [PTR_W-1:0]       rd_ptr_q [NUM_CLS];
   logic [PTR_W-1:0]       rd_ptr_d [NUM_CLS];
   logic [CNT_W-1:0]       cnt_q    [NUM_CLS];
   logic [CNT_W-1:0]       cnt_d    [NUM_CLS];
   logic [STALL_CNT_W-1:0] stall_q;
   logic [STALL_CNT_W-1:0] stall_d;
   logic [ENTRY_W-1:0]     mem_q    [NUM_CLS][QUEUE_DEPTH];

   // SOPP sits inside the 2'b10 scalar space, so it must be tested first.
   always_comb begin
      if (in_data[31:23] == 9'h17F)      cls = CLS_BRANCH;
      else if (in_data[31:30] == 2'b10)  cls = CLS_SALU;
      else if (!in_data[31])             cls = CLS_VALU;
      else                               cls = CLS_MEM;
   end

   always_comb begin
      out_data = '0;
      for (int unsigned c = 0; c < NUM_CLS; c++) begin
         valid_vec[c] = (cnt_q[c] != '0);
         full_vec[c]  = (cnt_q[c] == CNT_W'(QUEUE_DEPTH));
         out_data[c*ENTRY_W +: ENTRY_W] = mem_q[c][rd_ptr_q[c]];
      end
   end

   // Ready looks only at registered occupancy, so a pop on a full queue
   // does not open it for a push in the same cycle.
   always_comb begin
      in_ready_int = rst_n & ~flush & ~full_vec[cls];
      accept       = in_valid & in_ready_int;
      push_vec     = accept ? (4'b0001 << cls) : '0;
      pop_vec      = valid_vec & out_ready;
      entry_d      = {in_wf_id, in_data};
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_CLS; c++) begin
         wr_ptr_d[c] = wr_ptr_q[c];
         rd_ptr_d[c] = rd_ptr_q[c];
         cnt_d[c]    = cnt_q[c];
         if (flush) begin
            wr_ptr_d[c] = '0;
            rd_ptr_d[c] = '0;
            cnt_d[c]    = '0;
         end else begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push_vec[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop_vec[c]);
            cnt_d[c]    = cnt_q[c] + CNT_W'(push_vec[c]) - CNT_W'(pop_vec[c]);
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (in_valid && !in_ready_int && (stall_q != '1))
         stall_d = stall_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NUM_CLS; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         stall_q <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CLS; c++) begin
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
            cnt_q[c]    <= cnt_d[c];
         end
         stall_q <= stall_d;
      end
   end

   // Storage needs no reset; entries are only observable when counted.
   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CLS; c++) begin
         if (push_vec[c]) mem_q[c][wr_ptr_q[c]] <= entry_d;
      end
   end

   assign in_ready    = in_ready_int;
   assign out_valid   = valid_vec;
   assign q_full      = full_vec;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_dispatch_queue
//   Directed bench for instr_dispatch_queue with default parameters
//   (32-bit instructions, 4-bit wavefront ID, 4-deep queues, 16-bit stall
//   counter). Expected values are hand-derived. A small occupancy model
//   supplies them for the wrap-around stream.
// -----------------------------------------------------------------------------
module tb_instr_dispatch_queue;

   localparam int ENTRY_W = 36;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic [3:0]   in_wf_id;
   logic         flush;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [143:0] out_data;
   logic [3:0]   q_full;
   logic [15:0]  stall_count;

   instr_dispatch_queue #(
      .INSTR_SIZE  (32),
      .WF_ID_W     (4),
      .QUEUE_DEPTH (4),
      .STALL_CNT_W (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_wf_id    (in_wf_id),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .q_full      (q_full),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic         rdy;
   logic [3:0]   pre_valid;
   logic [143:0] pre_data;
   int           exp_stall;
   int           pi, ci, occ;
   logic         tog, v, exp_rdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] sl(input logic [143:0] d, input int c);
      return d[c*ENTRY_W +: ENTRY_W];
   endfunction

   // Apply inputs, snapshot pre-edge outputs, advance one edge, settle.
   task automatic cyc(input logic vld, input logic [31:0] d, input logic [3:0] wf,
                      input logic [3:0] ordy, input logic fl);
      in_valid  = vld;
      in_data   = d;
      in_wf_id  = wf;
      out_ready = ordy;
      flush     = fl;
      #1;
      rdy       = in_ready;
      pre_valid = out_valid;
      pre_data  = out_data;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_wf_id = '0;
      out_ready = '0; flush = 1'b0; exp_stall = 0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_valid", out_valid, 4'b0000);
      check("rst_full",  q_full, 4'b0000);
      check("rst_ready", in_ready, 1'b0);
      check("rst_stall", stall_count, 16'd0);
      rst_n = 1'b1;

      // Classification: one word per class, all consumers ready.
      cyc(1'b1, 32'hBF800000, 4'd1, 4'hF, 1'b0);
      check("cls_nobypass", pre_valid, 4'b0000);
      check("cls_rdy_sopp", rdy, 1'b1);
      check("cls_v_sopp", out_valid, 4'b0010);
      check("cls_d_sopp", sl(out_data, 1), {4'd1, 32'hBF800000});
      cyc(1'b1, 32'h81000102, 4'd2, 4'hF, 1'b0);
      check("cls_v_sop2", out_valid, 4'b0001);
      check("cls_d_sop2", sl(out_data, 0), {4'd2, 32'h81000102});
      cyc(1'b1, 32'h02000102, 4'd3, 4'hF, 1'b0);
      check("cls_v_vop2", out_valid, 4'b0100);
      check("cls_d_vop2", sl(out_data, 2), {4'd3, 32'h02000102});
      cyc(1'b1, 32'hE0500000, 4'd4, 4'hF, 1'b0);
      check("cls_v_mem", out_valid, 4'b1000);
      check("cls_d_mem", sl(out_data, 3), {4'd4, 32'hE0500000});
      cyc(1'b0, 32'h0, 4'd0, 4'hF, 1'b0);
      check("cls_drained", out_valid, 4'b0000);
      check("cls_stall", stall_count, 16'd0);

      // Fill SALU with no consumer.
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 32'h80000000 + 32'(i), 4'd5, 4'h0, 1'b0);
         check("fill_rdy", rdy, 1'b1);
      end
      check("fill_full", q_full, 4'b0001);
      check("fill_valid", out_valid, 4'b0001);
      cyc(1'b1, 32'h80000005, 4'd5, 4'h0, 1'b0);
      check("fill_blk1", rdy, 1'b0);
      check("fill_stall1", stall_count, 16'd1);
      cyc(1'b1, 32'h80000005, 4'd5, 4'h0, 1'b0);
      check("fill_blk2", rdy, 1'b0);
      check("fill_stall2", stall_count, 16'd2);
      cyc(1'b1, 32'h00000AAA, 4'd6, 4'h0, 1'b0);
      check("fill_valu_rdy", rdy, 1'b1);
      check("fill_valu_v", out_valid, 4'b0101);
      check("fill_stall3", stall_count, 16'd2);

      // Full SALU queue popped while a SALU push is offered.
      cyc(1'b1, 32'h80000005, 4'd5, 4'b0001, 1'b0);
      check("fp_rdy", rdy, 1'b0);
      check("fp_head", sl(pre_data, 0), {4'd5, 32'h80000001});
      check("fp_full", q_full, 4'b0000);
      check("fp_stall", stall_count, 16'd3);
      cyc(1'b1, 32'h80000005, 4'd5, 4'b0000, 1'b0);
      check("fp_rdy2", rdy, 1'b1);
      check("fp_full2", q_full, 4'b0001);
      for (int i = 2; i <= 5; i++) begin
         cyc(1'b0, 32'h0, 4'd0, 4'b0001, 1'b0);
         check("fp_order", sl(pre_data, 0), {4'd5, 32'h80000000 + 32'(i)});
      end
      check("fp_left", out_valid, 4'b0100);
      cyc(1'b0, 32'h0, 4'd0, 4'b0100, 1'b0);
      check("fp_valu", sl(pre_data, 2), {4'd6, 32'h00000AAA});
      check("fp_empty", out_valid, 4'b0000);
      exp_stall = 3;

      // Wrap-around: 10 VALU words, consumer ready every other cycle.
      pi = 0; ci = 0; occ = 0;
      for (int k = 0; k < 60 && ci < 10; k++) begin
         tog     = (k % 2 == 0);
         v       = (pi < 10);
         exp_rdy = (occ != 4);
         cyc(v, 32'h00001000 + 32'(pi), 4'(pi), {1'b0, tog, 2'b00}, 1'b0);
         check("wrap_rdy", rdy, exp_rdy);
         check("wrap_valid", pre_valid[2], occ != 0);
         if (occ != 0 && tog) begin
            check("wrap_data", sl(pre_data, 2), {4'(ci), 32'h00001000 + 32'(ci)});
            ci++;
            occ--;
         end
         if (v && exp_rdy) begin
            pi++;
            occ++;
         end
         if (v && !exp_rdy) exp_stall++;
      end
      check("wrap_done", 64'(ci), 64'd10);
      check("wrap_stall", stall_count, 16'(exp_stall));

      // Flush with MEM holding 3 and BRANCH holding 2.
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0000000 + 32'(i), 4'd7, 4'h0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b1, 32'hBF800000 + 32'(i), 4'd8, 4'h0, 1'b0);
      check("fl_pre", out_valid, 4'b1010);
      cyc(1'b1, 32'hC0000009, 4'd7, 4'hF, 1'b1);
      exp_stall++;
      check("fl_rdy", rdy, 1'b0);
      check("fl_valid", out_valid, 4'b0000);
      check("fl_full", q_full, 4'b0000);
      check("fl_stall", stall_count, 16'(exp_stall));
      cyc(1'b1, 32'h00000BBB, 4'd9, 4'h0, 1'b0);
      check("fl_post_v", out_valid, 4'b0100);
      check("fl_post_d", sl(out_data, 2), {4'd9, 32'h00000BBB});

      // Asynchronous reset mid-stream.
      in_valid = 1'b1; in_data = 32'h80000077; in_wf_id = 4'd3; out_ready = '0;
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 4'b0000);
      check("ar_ready", in_ready, 1'b0);
      check("ar_stall", stall_count, 16'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b1, 32'h80000077, 4'd3, 4'h0, 1'b0);
      check("ar_rdy", rdy, 1'b1);
      check("ar_nobypass", pre_valid, 4'b0000);
      check("ar_post_v", out_valid, 4'b0001);
      check("ar_post_d", sl(out_data, 0), {4'd3, 32'h80000077});
      check("ar_post_stall", stall_count, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
